vga_frame_mux: RTL and testbench

Parametrised, frame-synchronous video source selector for the VGA output path. It takes NUM_SRC independent sync/colour streams (start screen, game field, game-over screen, and future overlays) and routes exactly one to the VGA pins. Source changes are deferred to the leading vsync edge of the currently displayed stream, so no torn or partial frames reach the monitor. It replaces the fixed three-way screen select in the top level and adds request queuing, a missing-vsync timeout and optional switch blanking.

---
 rtl/vga_frame_mux.sv | 209 ++++++++++++++++++++
 tb/tb_vga_frame_mux.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_mux.sv
// vga_frame_mux: frame-synchronous selector that routes one of NUM_SRC VGA sync/colour
// streams to the output pins. Source changes requested on sel/sel_valid are deferred to
// the leading vsync edge of the currently routed stream, or forced after TIMEOUT_CYC
// cycles without such an edge, so the monitor never sees a torn frame.
//
// Ports:
//   clk, rst                  pixel clock, synchronous active-high reset
//   sel, sel_valid            requested source index and its one-cycle strobe
//   src_hsync, src_vsync      per-source syncs, bit i = source i
//   src_red/green/blue        packed colours, source i at [i*COLOR_W +: COLOR_W]
//   hsync_out, vsync_out      registered syncs of the routed source
//   red_out/green_out/blue_out registered colours of the routed source
//   cur_sel                   source currently routed
//   switch_busy               a request is pending
//   frame_done                one-cycle pulse per leading vsync edge of the routed source
//
// Optional feature: define VGA_FRAME_MUX_SWITCH_BLANK_EN to blank the colour outputs for
// the first frame after every switch (until the new source's first leading vsync edge).
module vga_frame_mux #(
    parameter int unsigned NUM_SRC          = 3,
    parameter int unsigned COLOR_W          = 1,
    parameter int unsigned VSYNC_ACTIVE_LOW = 1,
    parameter int unsigned TIMEOUT_CYC      = 2097152,
    localparam int unsigned SEL_W           = $clog2(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       sel_valid,
    input  logic [NUM_SRC-1:0]         src_hsync,
    input  logic [NUM_SRC-1:0]         src_vsync,
    input  logic [NUM_SRC*COLOR_W-1:0] src_red,
    input  logic [NUM_SRC*COLOR_W-1:0] src_green,
    input  logic [NUM_SRC*COLOR_W-1:0] src_blue,
    output logic                       hsync_out,
    output logic                       vsync_out,
    output logic [COLOR_W-1:0]         red_out,
    output logic [COLOR_W-1:0]         green_out,
    output logic [COLOR_W-1:0]         blue_out,
    output logic [SEL_W-1:0]           cur_sel,
    output logic                       switch_busy,
    output logic                       frame_done
);

    localparam int unsigned CNT_W = 22;
    localparam logic        ACT_LVL  = (VSYNC_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic        IDLE_LVL = ~ACT_LVL;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [SEL_W:0]   NUM_SRC_W = (SEL_W + 1)'(NUM_SRC);

    typedef enum logic {StIdle, StPending} state_e;

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]   pend_sel_q, pend_sel_d;
    logic               vs_prev_q, vs_prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               hsync_q, vsync_q, frame_done_q;
    logic [COLOR_W-1:0] red_q, green_q, blue_q;
    logic [COLOR_W-1:0] red_d, green_d, blue_d;

    // Routed-source and pending-source taps.
    logic               hs_cur, vs_cur, vs_new;
    logic [COLOR_W-1:0] red_cur, green_cur, blue_cur;

    logic lead_edge, timeout_hit, req_ok, do_switch;

    always_comb begin
        hs_cur    = src_hsync[0];
        vs_cur    = src_vsync[0];
        vs_new    = src_vsync[0];
        red_cur   = src_red[0 +: COLOR_W];
        green_cur = src_green[0 +: COLOR_W];
        blue_cur  = src_blue[0 +: COLOR_W];
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (cur_sel_q == SEL_W'(i)) begin
                hs_cur    = src_hsync[i];
                vs_cur    = src_vsync[i];
                red_cur   = src_red[i*COLOR_W +: COLOR_W];
                green_cur = src_green[i*COLOR_W +: COLOR_W];
                blue_cur  = src_blue[i*COLOR_W +: COLOR_W];
            end
            if (pend_sel_q == SEL_W'(i)) begin
                vs_new = src_vsync[i];
            end
        end
    end

    assign lead_edge   = (vs_cur == ACT_LVL) && (vs_prev_q != ACT_LVL);
    assign timeout_hit = (state_q == StPending) && (cnt_q == CNT_LAST);
    assign req_ok      = sel_valid && ({1'b0, sel} < NUM_SRC_W);

    always_comb begin
        state_d    = state_q;
        cur_sel_d  = cur_sel_q;
        pend_sel_d = pend_sel_q;
        vs_prev_d  = vs_cur;
        do_switch  = 1'b0;
        if (lead_edge) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (req_ok && (sel != cur_sel_q)) begin
                    pend_sel_d = sel;
                    state_d    = StPending;
                    // Timeout window is measured from the moment a request is latched.
                    cnt_d      = '0;
                end
            end
            StPending: begin
                if (lead_edge || timeout_hit) begin
                    do_switch = 1'b1;
                    cur_sel_d = pend_sel_q;
                    // Start edge detection from the new source's present level.
                    vs_prev_d = vs_new;
                    cnt_d     = '0;
                    // A coincident request is judged against the source just switched to.
                    if (req_ok && (sel != pend_sel_q)) begin
                        pend_sel_d = sel;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (req_ok) begin
                    if (sel == cur_sel_q) begin
                        state_d = StIdle;
                    end else begin
                        pend_sel_d = sel;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef VGA_FRAME_MUX_SWITCH_BLANK_EN
    logic blank_q, blank_d;

    always_comb begin
        blank_d = blank_q;
        if (do_switch) begin
            blank_d = 1'b1;
        end else if (lead_edge) begin
            blank_d = 1'b0;
        end
        red_d   = blank_d ? '0 : red_cur;
        green_d = blank_d ? '0 : green_cur;
        blue_d  = blank_d ? '0 : blue_cur;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blank_q <= 1'b0;
        end else begin
            blank_q <= blank_d;
        end
    end
`else
    always_comb begin
        red_d   = red_cur;
        green_d = green_cur;
        blue_d  = blue_cur;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            cur_sel_q    <= '0;
            pend_sel_q   <= '0;
            vs_prev_q    <= src_vsync[0];
            cnt_q        <= '0;
            hsync_q      <= IDLE_LVL;
            vsync_q      <= IDLE_LVL;
            red_q        <= '0;
            green_q      <= '0;
            blue_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_sel_q    <= cur_sel_d;
            pend_sel_q   <= pend_sel_d;
            vs_prev_q    <= vs_prev_d;
            cnt_q        <= cnt_d;
            hsync_q      <= hs_cur;
            vsync_q      <= vs_cur;
            red_q        <= red_d;
            green_q      <= green_d;
            blue_q       <= blue_d;
            frame_done_q <= lead_edge;
        end
    end

    assign hsync_out   = hsync_q;
    assign vsync_out   = vsync_q;
    assign red_out     = red_q;
    assign green_out   = green_q;
    assign blue_out    = blue_q;
    assign cur_sel     = cur_sel_q;
    assign switch_busy = (state_q == StPending);
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_vga_frame_mux.sv
// Self-checking bench for vga_frame_mux: directed reset/timeout/deferred-switch scenarios
// followed by randomized source streams and requests, all compared each cycle against a
// behavioural model of the selector.
module tb_vga_frame_mux;

    localparam int NSRC = 3;
    localparam int CW   = 4;
    localparam int TO   = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        sel;
    logic              sel_valid;
    logic [NSRC-1:0]   src_hsync, src_vsync;
    logic [NSRC*CW-1:0] src_red, src_green, src_blue;
    logic              hsync_out, vsync_out;
    logic [CW-1:0]     red_out, green_out, blue_out;
    logic [1:0]        cur_sel;
    logic              switch_busy, frame_done;

    vga_frame_mux #(
        .NUM_SRC          (NSRC),
        .COLOR_W          (CW),
        .VSYNC_ACTIVE_LOW (1),
        .TIMEOUT_CYC      (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sel         (sel),
        .sel_valid   (sel_valid),
        .src_hsync   (src_hsync),
        .src_vsync   (src_vsync),
        .src_red     (src_red),
        .src_green   (src_green),
        .src_blue    (src_blue),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out),
        .red_out     (red_out),
        .green_out   (green_out),
        .blue_out    (blue_out),
        .cur_sel     (cur_sel),
        .switch_busy (switch_busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Source stream generators: active-low vsync pulse of 3 cycles every len[i] cycles.
    int len [NSRC];
    int pos [NSRC];
    bit frozen [NSRC];

    // Reference model: who is routed, what is waiting (-1 = nothing), cycles since edge.
    int m_cur, m_pend, m_cnt;
    bit m_vsprev, m_blank;
    bit e_hs, e_vs, e_fd;
    int e_r, e_g, e_b;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic int colour_of(input logic [NSRC*CW-1:0] bus, input int s);
        logic [NSRC*CW-1:0] sh;
        sh = bus >> (s * CW);
        return int'(sh[CW-1:0]);
    endfunction

    task automatic gen_sources();
        for (int i = 0; i < NSRC; i++) begin
            src_vsync[i] = frozen[i] ? 1'b1 : (pos[i] < 3 ? 1'b0 : 1'b1);
            pos[i] = (pos[i] + 1) % len[i];
        end
        src_hsync = NSRC'($urandom);
        src_red   = (NSRC*CW)'($urandom);
        src_green = (NSRC*CW)'($urandom);
        src_blue  = (NSRC*CW)'($urandom);
    endtask

    // Advance the model by one clock using the inputs that the DUT is about to sample.
    task automatic model_step();
        bit lead, hit, sw, legal;
        if (rst) begin
            m_cur = 0; m_pend = -1; m_cnt = 0; m_vsprev = src_vsync[0]; m_blank = 0;
            e_hs = 1; e_vs = 1; e_fd = 0; e_r = 0; e_g = 0; e_b = 0;
            return;
        end
        lead  = (src_vsync[m_cur] == 1'b0) && m_vsprev;
        hit   = (m_pend >= 0) && (m_cnt == TO - 1);
        sw    = (m_pend >= 0) && (lead || hit);
        legal = sel_valid && (int'(sel) < NSRC);
        e_hs  = src_hsync[m_cur];
        e_vs  = src_vsync[m_cur];
        e_fd  = lead;
        if (sw) m_blank = 1;
        else if (lead) m_blank = 0;
`ifdef VGA_FRAME_MUX_SWITCH_BLANK_EN
        if (m_blank) begin
            e_r = 0; e_g = 0; e_b = 0;
        end else
`endif
        begin
            e_r = colour_of(src_red, m_cur);
            e_g = colour_of(src_green, m_cur);
            e_b = colour_of(src_blue, m_cur);
        end
        if (sw) begin
            m_cur    = m_pend;
            m_vsprev = src_vsync[m_cur];
            m_cnt    = 0;
            m_pend   = (legal && int'(sel) != m_cur) ? int'(sel) : -1;
        end else begin
            m_vsprev = src_vsync[m_cur];
            m_cnt    = lead ? 0 : (m_cnt < 32'h3f_ffff ? m_cnt + 1 : m_cnt);
            if (m_pend < 0) begin
                if (legal && int'(sel) != m_cur) begin
                    m_pend = int'(sel);
                    m_cnt  = 0;
                end
            end else if (legal) begin
                m_pend = (int'(sel) == m_cur) ? -1 : int'(sel);
            end
        end
    endtask

    task automatic check_all();
        check_val("cur_sel", 32'(cur_sel), 32'(m_cur));
        check_val("switch_busy", 32'(switch_busy), 32'(m_pend >= 0));
        check_val("frame_done", 32'(frame_done), 32'(e_fd));
        check_val("hsync_out", 32'(hsync_out), 32'(e_hs));
        check_val("vsync_out", 32'(vsync_out), 32'(e_vs));
        check_val("red_out", 32'(red_out), 32'(e_r));
        check_val("green_out", 32'(green_out), 32'(e_g));
        check_val("blue_out", 32'(blue_out), 32'(e_b));
    endtask

    // One clock: model consumes the present inputs, DUT samples them, compare at negedge.
    task automatic cyc();
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int k;
        bit fd_seen;
        rst = 1'b1;
        sel = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            len[i] = 100;
            pos[i] = 50;
            frozen[i] = 1'b1;
        end
        gen_sources();

        // Reset for three cycles.
        for (int i = 0; i < 3; i++) begin
            gen_sources();
            cyc();
        end
        check_val("reset_vsync", 32'(vsync_out), 32'd1);
        check_val("reset_hsync", 32'(hsync_out), 32'd1);
        rst = 1'b0;

        // No-op requests: out-of-range index and the current source.
        gen_sources(); sel = 2'd3; sel_valid = 1'b1; cyc();
        gen_sources(); sel = 2'd0; sel_valid = 1'b1; cyc();
        sel_valid = 1'b0;
        gen_sources(); cyc();
        check_val("noop_busy", 32'(switch_busy), 32'd0);

        // Timeout: all vsyncs held inactive, forced switch 64 cycles after latching.
        for (int i = 0; i < 10; i++) begin gen_sources(); cyc(); end
        gen_sources(); sel = 2'd1; sel_valid = 1'b1; cyc();
        sel_valid = 1'b0;
        k = 0;
        fd_seen = 1'b0;
        while (cur_sel != 2'd1 && k < 200) begin
            gen_sources(); cyc();
            k++;
            if (frame_done) fd_seen = 1'b1;
        end
        check_val("timeout_latency", 32'(k), 32'd64);
        check_val("timeout_no_frame_done", 32'(fd_seen), 32'd0);

        // Deferred switch, last-wins: request 0 then 2, then source 1 vsync falls.
        for (int i = 0; i < 5; i++) begin gen_sources(); cyc(); end
        gen_sources(); sel = 2'd0; sel_valid = 1'b1; cyc();
        gen_sources(); sel = 2'd2; sel_valid = 1'b1; cyc();
        sel_valid = 1'b0;
        for (int i = 0; i < 30; i++) begin gen_sources(); cyc(); end
        check_val("defer_busy", 32'(switch_busy), 32'd1);
        frozen[1] = 1'b0; pos[1] = 0; len[1] = 100;
        gen_sources(); cyc();
        check_val("defer_sel", 32'(cur_sel), 32'd2);
        check_val("defer_idle", 32'(switch_busy), 32'd0);

        // Cancel: request 1 then current (2); no switch on the following edge.
        frozen[2] = 1'b0; pos[2] = 10; len[2] = 40;
        gen_sources(); sel = 2'd1; sel_valid = 1'b1; cyc();
        gen_sources(); sel = 2'd2; sel_valid = 1'b1; cyc();
        sel_valid = 1'b0;
        check_val("cancel_busy", 32'(switch_busy), 32'd0);
        for (int i = 0; i < 40; i++) begin gen_sources(); cyc(); end
        check_val("cancel_sel", 32'(cur_sel), 32'd2);

        // Randomized phase with periodic re-configuration and one mid-run reset.
        for (int i = 0; i < NSRC; i++) begin
            frozen[i] = 1'b0;
            len[i] = int'($urandom_range(40, 200));
            pos[i] = int'($urandom_range(0, 39));
        end
        for (int c = 0; c < 15000; c++) begin
            if (c % 2000 == 1999) begin
                for (int i = 0; i < NSRC; i++) begin
                    len[i] = int'($urandom_range(20, 200));
                    pos[i] = 0;
                    frozen[i] = ($urandom_range(0, 5) == 0);
                end
            end
            rst = (c == 7000 || c == 7001);
            sel_valid = ($urandom_range(0, 29) == 0);
            sel = 2'($urandom_range(0, 3));
            gen_sources();
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
